// File: rtl/cv32e40p_ifst_breakage_ctrl.sv
// rtl/cv32e40p_ifst_breakage_ctrl.sv - per-replica error counters, sticky breakage flags and a serial breakage report handshake
// Flat replica index b = 3*submodule + replica throughout.
module cv32e40p_ifst_breakage_ctrl #(
    parameter int unsigned              N_SUB              = 6,
    parameter int unsigned              INC_DEC_BIT        = 2,
    parameter logic [INC_DEC_BIT-1:0]   INCREMENT          = INC_DEC_BIT'(1),
    parameter logic [INC_DEC_BIT-1:0]   DECREMENT          = INC_DEC_BIT'(1),
    parameter int unsigned              BREAKING_THRESHOLD = 3,
    parameter int unsigned              COUNT_BIT          = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       err_valid_i,
    input  logic [3*N_SUB-1:0]         err_i,
    input  logic                       clear_i,
    output logic [3*N_SUB-1:0]         broken_o,
    output logic [N_SUB-1:0]           degraded_o,
    output logic                       fatal_o,
    output logic                       rep_req_o,
    output logic [$clog2(N_SUB)-1:0]   rep_sub_o,
    output logic [1:0]                 rep_replica_o,
    input  logic                       rep_ack_i
);

    localparam int unsigned NB    = 3 * N_SUB;
    localparam int unsigned IDX_W = $clog2(NB);
    localparam int unsigned SUB_W = $clog2(N_SUB);
    localparam int unsigned CW    = COUNT_BIT + 1;

    localparam logic [CW-1:0] CNT_MAX = {1'b0, {COUNT_BIT{1'b1}}};
    localparam logic [CW-1:0] INC_X   = CW'(INCREMENT);
    localparam logic [CW-1:0] DEC_X   = CW'(DECREMENT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [COUNT_BIT-1:0] cnt_q [NB];
    logic [COUNT_BIT-1:0] cnt_d [NB];
    logic [NB-1:0]        broken_q, broken_d;
    logic [NB-1:0]        pending_q, pending_d;
    logic [NB-1:0]        new_brk;
    logic [NB-1:0]        ack_mask;
    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     rep_idx_q, rep_idx_d;
    logic [SUB_W-1:0]     rep_sub_q, rep_sub_d;
    logic [1:0]           rep_replica_q, rep_replica_d;

    logic [CW-1:0]        cnt_ext;
    logic [CW-1:0]        cnt_sum;
    logic [CW-1:0]        cnt_nx;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [SUB_W-1:0]     pick_sub;
    logic [1:0]           pick_rep;

    logic [1:0]           pop;

    // Counters of broken replicas freeze; arithmetic is one bit wider so saturation can see the carry.
    always_comb begin
        new_brk = '0;
        cnt_ext = '0;
        cnt_sum = '0;
        cnt_nx  = '0;
        for (int b = 0; b < NB; b++) begin
            cnt_ext = {1'b0, cnt_q[b]};
            cnt_sum = cnt_ext + INC_X;
            if (err_i[b]) begin
                cnt_nx = (cnt_sum > CNT_MAX) ? CNT_MAX : cnt_sum;
            end else begin
                cnt_nx = (cnt_ext < DEC_X) ? '0 : (cnt_ext - DEC_X);
            end
            cnt_d[b] = cnt_q[b];
            if (clear_i) begin
                cnt_d[b] = '0;
            end else if (err_valid_i && !broken_q[b]) begin
                cnt_d[b]   = cnt_nx[COUNT_BIT-1:0];
                new_brk[b] = (32'(cnt_nx) >= BREAKING_THRESHOLD);
            end
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sub   = '0;
        pick_rep   = '0;
        for (int b = 0; b < NB; b++) begin
            if (pending_q[b] && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(b);
                pick_sub   = SUB_W'(b / 3);
                pick_rep   = 2'(b % 3);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rep_idx_d     = rep_idx_q;
        rep_sub_d     = rep_sub_q;
        rep_replica_d = rep_replica_q;
        ack_mask      = '0;
        if (clear_i) begin
            state_d       = ST_IDLE;
            rep_idx_d     = '0;
            rep_sub_d     = '0;
            rep_replica_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        rep_idx_d     = pick_idx;
                        rep_sub_d     = pick_sub;
                        rep_replica_d = pick_rep;
                        state_d       = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rep_ack_i) begin
                        ack_mask[rep_idx_q] = 1'b1;
                        state_d             = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        if (clear_i) begin
            broken_d  = '0;
            pending_d = '0;
        end else begin
            broken_d  = broken_q | new_brk;
            pending_d = (pending_q & ~ack_mask) | new_brk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) begin
                cnt_q[b] <= '0;
            end
            broken_q      <= '0;
            pending_q     <= '0;
            state_q       <= ST_IDLE;
            rep_idx_q     <= '0;
            rep_sub_q     <= '0;
            rep_replica_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            broken_q      <= broken_d;
            pending_q     <= pending_d;
            state_q       <= state_d;
            rep_idx_q     <= rep_idx_d;
            rep_sub_q     <= rep_sub_d;
            rep_replica_q <= rep_replica_d;
        end
    end

    always_comb begin
        degraded_o = '0;
        fatal_o    = 1'b0;
        pop        = '0;
        for (int s = 0; s < N_SUB; s++) begin
            pop = 2'(broken_q[3*s]) + 2'(broken_q[3*s+1]) + 2'(broken_q[3*s+2]);
            degraded_o[s] = (pop == 2'd1);
            if (pop >= 2'd2) begin
                fatal_o = 1'b1;
            end
        end
    end

    assign broken_o      = broken_q;
    assign rep_req_o     = (state_q == ST_REQ);
    assign rep_sub_o     = rep_sub_q;
    assign rep_replica_o = rep_replica_q;

endmodule

// File: tb/tb_cv32e40p_ifst_breakage_ctrl.sv
// tb/tb_cv32e40p_ifst_breakage_ctrl.sv - directed and random checks of the breakage controller against a behavioural model
module tb_cv32e40p_ifst_breakage_ctrl;

    localparam int N_SUB = 6;
    localparam int NB    = 18;
    localparam int CMAX  = 255;
    localparam int TH    = 3;
    localparam int INC   = 1;
    localparam int DEC   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            err_valid_i = 1'b0;
    logic [NB-1:0]   err_i = '0;
    logic            clear_i = 1'b0;
    logic            rep_ack_i = 1'b0;
    logic [NB-1:0]   broken_o;
    logic [N_SUB-1:0] degraded_o;
    logic            fatal_o;
    logic            rep_req_o;
    logic [2:0]      rep_sub_o;
    logic [1:0]      rep_replica_o;

    logic            s_valid = 1'b0;
    logic [NB-1:0]   s_err = '0;
    logic            s_ack = 1'b0;
    logic [NB-1:0]   s_broken;
    logic [N_SUB-1:0] s_degraded;
    logic            s_fatal;
    logic            s_req;
    logic [2:0]      s_sub;
    logic [1:0]      s_replica;

    cv32e40p_ifst_breakage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .err_valid_i(err_valid_i), .err_i(err_i),
        .clear_i(clear_i), .broken_o(broken_o), .degraded_o(degraded_o),
        .fatal_o(fatal_o), .rep_req_o(rep_req_o), .rep_sub_o(rep_sub_o),
        .rep_replica_o(rep_replica_o), .rep_ack_i(rep_ack_i)
    );

    cv32e40p_ifst_breakage_ctrl #(
        .COUNT_BIT(2), .BREAKING_THRESHOLD(3), .INCREMENT(2'd3)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .err_valid_i(s_valid), .err_i(s_err),
        .clear_i(1'b0), .broken_o(s_broken), .degraded_o(s_degraded),
        .fatal_o(s_fatal), .rep_req_o(s_req), .rep_sub_o(s_sub),
        .rep_replica_o(s_replica), .rep_ack_i(s_ack)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_cnt  [NB];
    bit m_brk  [NB];
    bit m_pend [NB];
    bit m_req;
    int m_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_cnt[b] = 0; m_brk[b] = 0; m_pend[b] = 0;
        end
        m_req = 0;
        m_b = 0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs currently driven.
    function automatic void model_edge();
        bit newp [NB];
        int lo;
        if (clear_i) begin
            model_reset();
            return;
        end
        lo = -1;
        for (int b = 0; b < NB; b++) if (m_pend[b] && lo < 0) lo = b;
        for (int b = 0; b < NB; b++) begin
            newp[b] = 0;
            if (err_valid_i && !m_brk[b]) begin
                if (err_i[b]) m_cnt[b] = (m_cnt[b] + INC > CMAX) ? CMAX : m_cnt[b] + INC;
                else          m_cnt[b] = (m_cnt[b] - DEC < 0) ? 0 : m_cnt[b] - DEC;
                if (m_cnt[b] >= TH) begin
                    m_brk[b] = 1;
                    newp[b] = 1;
                end
            end
        end
        if (m_req) begin
            if (rep_ack_i) begin
                m_pend[m_b] = 0;
                m_req = 0;
            end
        end else if (lo >= 0) begin
            m_req = 1;
            m_b = lo;
        end
        for (int b = 0; b < NB; b++) if (newp[b]) m_pend[b] = 1;
    endfunction

    task automatic check_all();
        logic [NB-1:0] bv;
        logic [N_SUB-1:0] dv;
        logic fv;
        int c;
        fv = 1'b0;
        for (int b = 0; b < NB; b++) bv[b] = m_brk[b];
        for (int s = 0; s < N_SUB; s++) begin
            c = int'(m_brk[3*s]) + int'(m_brk[3*s+1]) + int'(m_brk[3*s+2]);
            dv[s] = (c == 1);
            if (c >= 2) fv = 1'b1;
        end
        chk("broken", broken_o, bv);
        chk("degraded", degraded_o, dv);
        chk("fatal", fatal_o, fv);
        chk("rep_req", rep_req_o, m_req);
        if (m_req) begin
            chk("rep_sub", rep_sub_o, m_b / 3);
            chk("rep_replica", rep_replica_o, m_b % 3);
        end
    endtask

    task automatic step(input bit v, input logic [NB-1:0] e, input bit clr, input bit ack);
        err_valid_i = v;
        err_i = e;
        clear_i = clr;
        rep_ack_i = ack;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [NB-1:0] e;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_broken", broken_o, 0);
        chk("reset_req", rep_req_o, 0);
        chk("reset_sub", rep_sub_o, 0);
        chk("reset_replica", rep_replica_o, 0);
        chk("reset_degraded", degraded_o, 0);
        chk("reset_fatal", fatal_o, 0);
        chk("reset_sat_broken", s_broken, 0);
        rst_n = 1'b1;

        // basic breakage of sub 2 replica 1
        for (int i = 0; i < 3; i++) step(1, NB'(1) << 7, 0, 0);
        chk("basic_brk7", broken_o[7], 1);
        chk("basic_deg2", degraded_o[2], 1);
        chk("basic_no_req_yet", rep_req_o, 0);
        step(0, '0, 0, 0);
        chk("basic_req", rep_req_o, 1);
        chk("basic_sub", rep_sub_o, 2);
        chk("basic_replica", rep_replica_o, 1);
        step(0, '0, 0, 1);
        chk("basic_ack_drop", rep_req_o, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
        chk("basic_no_more", rep_req_o, 0);

        // up/down on bit 0 with ok-at-zero and valid-low holds
        step(1, '0, 0, 0);
        step(1, NB'(1), 0, 0);
        step(1, NB'(1), 0, 0);
        step(0, NB'(1), 0, 0);
        step(1, '0, 0, 0);
        step(1, NB'(1), 0, 0);
        step(0, '0, 0, 0);
        chk("updown_not_yet", broken_o[0], 0);
        step(1, NB'(1), 0, 0);
        chk("updown_brk0", broken_o[0], 1);
        step(0, '0, 0, 0);
        chk("updown_sub", rep_sub_o, 0);
        step(0, '0, 0, 1);

        // simultaneous breakage reported in ascending order
        step(0, '0, 1, 0);
        chk("clear_broken", broken_o, 0);
        e = '0; e[2] = 1'b1; e[12] = 1'b1;
        for (int i = 0; i < 3; i++) step(1, e, 0, 0);
        step(0, '0, 0, 0);
        chk("order_first_sub", rep_sub_o, 0);
        chk("order_first_rep", rep_replica_o, 2);
        step(0, '0, 0, 1);
        chk("order_idle_gap", rep_req_o, 0);
        step(0, '0, 0, 0);
        chk("order_second_sub", rep_sub_o, 4);
        chk("order_second_rep", rep_replica_o, 0);
        step(0, '0, 0, 1);

        // two broken replicas in sub 3 are fatal until cleared
        step(0, '0, 1, 0);
        e = '0; e[9] = 1'b1; e[10] = 1'b1;
        for (int i = 0; i < 3; i++) step(1, e, 0, 0);
        chk("fatal_set", fatal_o, 1);
        chk("fatal_deg3", degraded_o[3], 0);
        for (int i = 0; i < 6; i++) step(0, '0, 0, i % 2 == 1);
        chk("fatal_sticky", fatal_o, 1);
        step(0, '0, 1, 0);
        chk("fatal_cleared", fatal_o, 0);

        // clear aborts an in-flight request; a later ack is inert
        for (int i = 0; i < 3; i++) step(1, NB'(1) << 4, 0, 0);
        step(0, '0, 0, 0);
        chk("abort_req_up", rep_req_o, 1);
        step(0, '0, 1, 0);
        chk("abort_req", rep_req_o, 0);
        chk("abort_broken", broken_o, 0);
        step(0, '0, 0, 1);
        chk("abort_late_ack", rep_req_o, 0);

        // saturating variant: one error reaches 3 and breaks
        s_valid = 1'b1; s_err = NB'(1) << 5;
        step(0, '0, 0, 0);
        chk("sat_brk", s_broken, 32'h20);
        s_valid = 1'b1; s_err = NB'(1) << 5;
        step(0, '0, 0, 0);
        chk("sat_frozen", s_broken, 32'h20);
        chk("sat_req", s_req, 1);
        chk("sat_sub", s_sub, 1);
        chk("sat_replica", s_replica, 2);
        s_valid = 1'b0; s_err = '0;

        // random traffic, including ack during clear and ack in idle
        for (int i = 0; i < 600; i++) begin
            e = NB'($urandom & $urandom & $urandom);
            step(bit'($urandom % 2), e, ($urandom % 40) == 0, bit'($urandom % 2));
        end

        // asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) step(1, NB'(1) << 15, 0, 0);
        step(0, '0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_broken", broken_o, 0);
        chk("areset_req", rep_req_o, 0);
        chk("areset_sub", rep_sub_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
